// File: rtl/intdiv_pkg.sv
// Shared constants and state encoding for the sequenced integer divider.
package intdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SETTLE_DEF = 2;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/intdiv_intdiv.sv
// Combinational signed array divider: restoring division on magnitudes,
// quotient truncated toward zero, remainder takes the dividend's sign.
module intdiv_intdiv #(
  parameter int N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] z,
  output logic [N-1:0] r
);

  logic [N-1:0] ax;
  logic [N-1:0] ay;
  logic [N-1:0] q;
  logic [N:0]   rem;

  always_comb begin
    // magnitude of -2^(N-1) is 2^(N-1), which still fits N unsigned bits
    ax  = x[N-1] ? ({N{1'b0}} - x) : x;
    ay  = y[N-1] ? ({N{1'b0}} - y) : y;
    q   = '0;
    rem = '0;
    for (int i = N - 1; i >= 0; i--) begin
      rem = {rem[N-1:0], ax[i]};
      if (rem >= {1'b0, ay}) begin
        rem  = rem - {1'b0, ay};
        q[i] = 1'b1;
      end
    end
    z = (x[N-1] ^ y[N-1]) ? ({N{1'b0}} - q) : q;
    r = x[N-1] ? ({N{1'b0}} - rem[N-1:0]) : rem[N-1:0];
  end

endmodule

// File: rtl/intdiv_seq_ctrl.sv
// Handshaked sequencer around intdiv_intdiv with a multicycle settle window.
// Optional handshake statistics counters: define INTDIV_SEQ_CTRL_STATS_EN.
//
// state | meaning
// IDLE  | ready for an operand pair
// CALC  | array settling, counting down
// DONE  | result presented, waiting for out_ready
module intdiv_seq_ctrl
  import intdiv_pkg::*;
#(
  parameter int N      = 5,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic [N-1:0] r,
  output logic         dz,
  output logic         ovf
`ifdef INTDIV_SEQ_CTRL_STATS_EN
  ,
  output logic [15:0]  op_cnt,
  output logic [15:0]  dz_cnt,
  output logic [15:0]  ovf_cnt
`endif
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     xa_q, xa_d, ya_q, ya_d;
  logic [N-1:0]     z_q, z_d, r_q, r_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;
  logic [N-1:0]     az, ar;

  intdiv_intdiv #(.N(N)) u_array (
    .x (xa_q),
    .y (ya_q),
    .z (az),
    .r (ar)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    z_d     = z_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xa_d = x;
          ya_d = y;
          if (y == '0) begin
            z_d     = '1;
            r_d     = x;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else if (x == MOST_NEG && y == '1) begin
            z_d     = x;
            r_d     = '0;
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(SETTLE - 1);
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          z_d     = az;
          r_d     = ar;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      z_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      z_q     <= z_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;
  assign r         = r_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

`ifdef INTDIV_SEQ_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt  <= '0;
      dz_cnt  <= '0;
      ovf_cnt <= '0;
    end else if (state_q == DONE && out_ready) begin
      op_cnt <= op_cnt + 16'd1;
      if (dz_q)  dz_cnt  <= dz_cnt + 16'd1;
      if (ovf_q) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_intdiv_seq_ctrl.sv
// Directed bench for intdiv_seq_ctrl (N=5, SETTLE=2) with an exhaustive sweep.
module tb_intdiv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] x = '0;
  logic [4:0] y = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] z, r;
  logic       dz, ovf;
`ifdef INTDIV_SEQ_CTRL_STATS_EN
  logic [15:0] op_cnt, dz_cnt, ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  intdiv_seq_ctrl #(.N(5), .SETTLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .r         (r),
    .dz        (dz),
    .ovf       (ovf)
`ifdef INTDIV_SEQ_CTRL_STATS_EN
    ,
    .op_cnt    (op_cnt),
    .dz_cnt    (dz_cnt),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // accept one operand pair, then wait (bounded) for out_valid and check latency
  task automatic start_op(input logic [4:0] a, input logic [4:0] b, input int exp_lat);
    int lat;
    chk("in_ready_before_accept", in_ready, 1);
    x = a;
    y = b;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic chk_res(input string tag, input logic [4:0] ez, input logic [4:0] er,
                         input logic edz, input logic eovf);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, dz, edz);
    chk({tag, "_ovf"}, ovf, eovf);
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    int qi, ri, lat;
    logic [4:0] ez, er;

    // reset state
    tick;
    tick;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk_res("rst", 5'd0, 5'd0, 1'b0, 1'b0);

    // 7/2 with cycle-by-cycle timing; in_valid during CALC must be ignored
    x = 5'd7;
    y = 5'd2;
    in_valid = 1'b1;
    tick;
    chk("t1_in_ready_fall", in_ready, 0);
    chk("t1_ov_c1", out_valid, 0);
    x = 5'd9;
    y = 5'd3;
    tick;
    chk("t1_ov_c2", out_valid, 0);
    chk("t1_in_ready_c2", in_ready, 0);
    tick;
    in_valid = 1'b0;
    chk("t1_ov_c3", out_valid, 1);
    chk_res("t1", 5'd3, 5'd1, 1'b0, 1'b0);
    handshake;
    chk("t1_z_held", z, 5'd3);
    chk("t1_r_held", r, 5'd1);

    // signed normal cases
    start_op(5'b11001, 5'd2, 3);
    chk_res("neg_x", 5'b11101, 5'b11111, 1'b0, 1'b0);
    handshake;
    start_op(5'd7, 5'b11110, 3);
    chk_res("neg_y", 5'b11101, 5'd1, 1'b0, 1'b0);
    handshake;

    // special cases
    start_op(5'd7, 5'd0, 1);
    chk_res("div0", 5'b11111, 5'd7, 1'b1, 1'b0);
    handshake;
    chk("div0_dz_held", dz, 1);
    start_op(5'b10000, 5'b11111, 1);
    chk_res("ovf", 5'b10000, 5'd0, 1'b0, 1'b1);
    handshake;

`ifdef INTDIV_SEQ_CTRL_STATS_EN
    chk("stats_op", op_cnt, 16'd5);
    chk("stats_dz", dz_cnt, 16'd1);
    chk("stats_ovf", ovf_cnt, 16'd1);
`endif

    // back-pressure then back-to-back accept
    start_op(5'd13, 5'd4, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_z", z, 5'd3);
      chk("bp_r", r, 5'd1);
      tick;
    end
    handshake;
    start_op(5'b10011, 5'd4, 3);
    chk_res("b2b", 5'b11101, 5'b11111, 1'b0, 1'b0);
    handshake;

    // reset mid-CALC with counter still at 1
    x = 5'd7;
    y = 5'd2;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("pre_rst_calc", in_ready, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk_res("mid_rst", 5'd0, 5'd0, 1'b0, 1'b0);
`ifdef INTDIV_SEQ_CTRL_STATS_EN
    chk("stats_rst_op", op_cnt, 16'd0);
`endif
    start_op(5'd9, 5'd3, 3);
    chk_res("after_rst", 5'd3, 5'd0, 1'b0, 1'b0);
    handshake;

    // exhaustive sweep against native signed arithmetic, wrapped to 5 bits
    for (int xi = -16; xi < 16; xi++) begin
      for (int yi = -16; yi < 16; yi++) begin
        if (yi != 0) begin
          qi  = xi / yi;
          ri  = xi % yi;
          ez  = 5'(qi);
          er  = 5'(ri);
          lat = (xi == -16 && yi == -1) ? 1 : 3;
          start_op(5'(xi), 5'(yi), lat);
          chk_res("sweep", ez, er, 1'b0, (xi == -16 && yi == -1));
          handshake;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
